// File: rtl/mem_bus_pkg.sv
// Shared widths and types for the cache-to-memory line bus.
// Used by the I-cache, D-cache and the slow memory responder.
package mem_bus_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 28;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_e;

    // Request captured at acceptance; the transaction completes from this copy.
    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/slow_mem_responder_if.sv
// Cache-to-memory line bus: held request from the initiator, one-cycle ready from memory.
interface slow_mem_responder_if;
    import mem_bus_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              proto_err;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, proto_err
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, proto_err
    );

endinterface

// File: rtl/slow_mem_responder_line_ram.sv
// Line storage: 2^IDX_W x LINE_W, synchronous write, asynchronous read, no reset.
// Contents survive rst_n; simulation preloads it hierarchically.
module line_ram
    import mem_bus_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LINE_W-1:0] wdata,
    output logic [LINE_W-1:0] rdata
);

    logic [LINE_W-1:0] mem [1<<IDX_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/slow_mem_responder.sv
// Slow line memory: one read/write per transaction, mem_ready pulse LATENCY cycles after accept.
// No backpressure: initiator holds the request until mem_ready; deviations set sticky proto_err.
module slow_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int LATENCY = 8,
    parameter int IDX_W   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    slow_mem_responder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    mem_req_t          req_q;
    logic              perr_q;
    logic              viol;
    logic              req_vld;
    logic              accept;
    logic              ram_we;
    logic [LINE_W-1:0] ram_rdata;

    assign req_vld = bus.mem_read | bus.mem_write;
    assign accept  = (state == IDLE) && req_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // BUSY leaves on the edge that takes the counter to zero, so RESP lands LATENCY cycles after accept.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_vld) begin
                    cnt_nxt   = CNT_LOAD;
                    state_nxt = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.wr    <= bus.mem_write;
            req_q.addr  <= bus.mem_addr;
            req_q.wdata <= bus.mem_wdata;
        end
    end

    // Any departure from the held request while the transaction is in flight is a violation.
    always_comb begin
        viol = 1'b0;
        if (bus.mem_read && bus.mem_write) begin
            viol = 1'b1;
        end
        if (state != IDLE) begin
            if (!req_vld) begin
                viol = 1'b1;
            end
            if (bus.mem_write != req_q.wr) begin
                viol = 1'b1;
            end
            if (bus.mem_addr != req_q.addr) begin
                viol = 1'b1;
            end
            if (req_q.wr && (bus.mem_wdata != req_q.wdata)) begin
                viol = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perr_q <= 1'b0;
        end else if (viol) begin
            perr_q <= 1'b1;
        end
    end

    assign ram_we = (state == RESP) && req_q.wr;

    line_ram #(
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .idx   (req_q.addr[IDX_W-1:0]),
        .wdata (req_q.wdata),
        .rdata (ram_rdata)
    );

    assign bus.mem_ready = (state == RESP);
    assign bus.mem_rdata = ((state == RESP) && !req_q.wr) ? ram_rdata : '0;
    assign bus.proto_err = perr_q;

endmodule
